// File: rtl/token_rr_scheduler_pkg.sv
// Shared constants and helpers for the token round-robin scheduler.
//   DIV_RESET : decimation ratio after reset (pure halving)
//   norm_div  : maps a requested ratio to its stored value (0 and 1 both mean "pass all")
//   next_ptr  : round-robin successor of a requester index
package token_sched_pkg;

  localparam int unsigned DIV_RESET = 2;

  // Ratios below 1 are meaningless; clamp to 1.
  function automatic int unsigned norm_div(input int unsigned cfg);
    return (cfg < 1) ? 1 : cfg;
  endfunction

  // Index after idx, wrapping at n.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/token_rr_scheduler_if.sv
// Token scheduler bus: serial token in, config, requests; decimated token out, grants, drop count.
//   master : token source / consumer bank side
//   slave  : scheduler side
interface token_rr_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DIV_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             a;
  logic             cfg_load;
  logic [DIV_W-1:0] cfg_div;
  logic [N_REQ-1:0] req;
  logic             b;
  logic [N_REQ-1:0] gnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (output a, cfg_load, cfg_div, req, input  b, gnt, drop_cnt);
  modport slave  (input  a, cfg_load, cfg_div, req, output b, gnt, drop_cnt);
endinterface

// File: rtl/token_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index for this search
//   en      : grant enable (a token is being handed out)
//   gnt     : one-hot grant, zero when !en or no request
//   gnt_idx : index of the first request at or above ptr (modulo N_REQ)
//   any     : at least one request is asserted
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  logic        found;
  int unsigned idx;

  // Rotating search starting at ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    any     = |req;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!found && req[PTR_W'(idx)]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/token_rr_scheduler.sv
// Serial token decimator with round-robin distribution.
// Passes one of every div_reg tokens on bus.a (zero latency onto bus.b) and grants
// each passed token to a requester in round-robin order; passed tokens with no
// requester are counted in a saturating drop counter.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : slave side of token_rr_scheduler_if
module token_rr_scheduler
  import token_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DIV_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  token_rr_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [DIV_W-1:0] div_reg_q, div_reg_d;
  logic [DIV_W-1:0] tok_cnt_q, tok_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             at_last;
  logic             pass;
  logic             any;
  logic [PTR_W-1:0] gnt_idx;
  logic [N_REQ-1:0] arb_gnt;

  // Token passes when it is the last of the current group; rst gating keeps
  // outputs low during reset independent of state.
  assign at_last = (tok_cnt_q == div_reg_q - DIV_W'(1));
  assign pass    = bus.a & at_last & rst;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .en      (pass),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign bus.b        = pass;
  assign bus.gnt      = arb_gnt;
  assign bus.drop_cnt = drop_cnt_q;

  // Next-state: the current token is judged with the old ratio even if a load arrives.
  always_comb begin
    div_reg_d  = div_reg_q;
    tok_cnt_d  = tok_cnt_q;
    ptr_d      = ptr_q;
    drop_cnt_d = drop_cnt_q;

    if (bus.a) tok_cnt_d = at_last ? '0 : tok_cnt_q + DIV_W'(1);

    if (bus.cfg_load) begin
      div_reg_d = DIV_W'(norm_div(32'(bus.cfg_div)));
      tok_cnt_d = '0;
    end

    if (pass && any) ptr_d = PTR_W'(next_ptr(32'(gnt_idx), N_REQ));

    if (pass && !any && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg_q  <= DIV_W'(DIV_RESET);
      tok_cnt_q  <= '0;
      ptr_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      div_reg_q  <= div_reg_d;
      tok_cnt_q  <= tok_cnt_d;
      ptr_q      <= ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_token_rr_scheduler.sv
// Scoreboard bench for token_rr_scheduler: a driver applies directed and random
// stimulus one cycle at a time and pushes the reference model's expected outputs;
// a monitor pops and compares on the falling edge.
module tb_token_rr_scheduler;

  localparam int unsigned N = 4;

  typedef struct {
    logic       b;
    logic [3:0] gnt;
    logic [7:0] drop;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb_q[$];
  bit   done;

  // Reference model state: ratio, tokens seen since last load/reset, rr pointer, drops.
  int div_m;
  int seen_m;
  int ptr_m;
  int drop_m;

  token_rr_scheduler_if bus ();

  token_rr_scheduler #(.N_REQ(4), .DIV_W(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    div_m  = 2;
    seen_m = 0;
    ptr_m  = 0;
    drop_m = 0;
  endtask

  // One active cycle: drive inputs, push expectation, advance the model across the edge.
  task automatic step(input logic a_i, input logic [3:0] req_i, input logic ld, input logic [3:0] div_i);
    exp_t e;
    bit   pass_m;
    int   gidx;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.a        = a_i;
    bus.req      = req_i;
    bus.cfg_load = ld;
    bus.cfg_div  = div_i;
    pass_m = a_i && (((seen_m + 1) % div_m) == 0);
    gidx   = -1;
    if (pass_m) begin
      for (int k = 0; k < N; k++) begin
        if (gidx < 0 && req_i[(ptr_m + k) % N]) gidx = (ptr_m + k) % N;
      end
    end
    e.b    = pass_m;
    e.gnt  = (gidx >= 0) ? 4'(1 << gidx) : 4'b0;
    e.drop = 8'(drop_m);
    sb_q.push_back(e);
    if (a_i) seen_m++;
    if (pass_m) begin
      if (gidx >= 0) ptr_m = (gidx + 1) % N;
      else if (drop_m < 255) drop_m++;
    end
    if (ld) begin
      div_m  = (div_i == 0) ? 1 : int'(div_i);
      seen_m = 0;
    end
  endtask

  // One cycle held in reset.
  task automatic step_rst();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.a        = 1'($urandom_range(0, 1));
    bus.req      = 4'($urandom_range(0, 15));
    bus.cfg_load = 1'b0;
    e.b = 1'b0; e.gnt = 4'b0; e.drop = 8'd0;
    sb_q.push_back(e);
    model_reset();
  endtask

  // Reset asserted between edges while a token would otherwise pass.
  task automatic step_mid_reset(input logic [3:0] req_i);
    exp_t e;
    @(posedge clk);
    #1;
    bus.a        = 1'b1;
    bus.req      = req_i;
    bus.cfg_load = 1'b0;
    #2;
    rst_n = 1'b0;
    e.b = 1'b0; e.gnt = 4'b0; e.drop = 8'd0;
    sb_q.push_back(e);
    model_reset();
  endtask

  // Monitor: compare presented outputs against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks += 3;
      if (bus.b !== e.b) begin
        failures++;
        $display("FAIL b @%0t: got %b expected %b", $time, bus.b, e.b);
      end
      if (bus.gnt !== e.gnt) begin
        failures++;
        $display("FAIL gnt @%0t: got %b expected %b", $time, bus.gnt, e.gnt);
      end
      if (bus.drop_cnt !== e.drop) begin
        failures++;
        $display("FAIL drop_cnt @%0t: got %0d expected %0d", $time, bus.drop_cnt, e.drop);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.a = 1'b0;
    bus.req = '0;
    bus.cfg_load = 1'b0;
    bus.cfg_div = '0;
    model_reset();
    repeat (2) step_rst();

    // 1: default halving, single requester
    pat = 16'b1100111010001111;
    for (int i = 15; i >= 0; i--) step(pat[i], 4'b0001, 1'b0, 4'd0);

    // 2: all requesters, full rotation
    repeat (8) step(1'b1, 4'b1111, 1'b0, 4'd0);

    // 3: sparse requests, then drops
    repeat (6) step(1'b1, 4'b0101, 1'b0, 4'd0);
    repeat (4) step(1'b1, 4'b0000, 1'b0, 4'd0);

    // 4: ratio 3, then ratio 0 -> pass everything
    step(1'b0, 4'b1111, 1'b1, 4'd3);
    repeat (9) step(1'b1, 4'b1111, 1'b0, 4'd0);
    step(1'b0, 4'b1010, 1'b1, 4'd0);
    repeat (6) step(1'b1, 4'b1010, 1'b0, 4'd0);
    step(1'b0, 4'b0000, 1'b1, 4'd1);
    repeat (3) step(1'b1, 4'b0100, 1'b0, 4'd0);

    // 5: load coincident with a passing token
    step_rst();
    step(1'b1, 4'b0011, 1'b0, 4'd0);
    step(1'b1, 4'b0011, 1'b1, 4'd4);
    repeat (9) step(1'b1, 4'b0011, 1'b0, 4'd0);

    // 6: async reset mid-stream, first token after release, saturation
    step(1'b0, 4'b0000, 1'b1, 4'd2);
    step(1'b1, 4'b0000, 1'b0, 4'd0);
    step_mid_reset(4'b1111);
    step_rst();
    repeat (3) step(1'b1, 4'b1111, 1'b0, 4'd0);
    repeat (600) step(1'b1, 4'b0000, 1'b0, 4'd0);
    repeat (10) step(1'b1, 4'b0000, 1'b0, 4'd0);

    // Random phase
    step_rst();
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)));
    end
    step(1'b0, 4'b0000, 1'b0, 4'd0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
